vi_sync_pulse_hs: RTL and testbench
===================================

Name: vi_sync_pulse_hs

Overview:
- Handshaked pulse crossing from clka to clkb with an acknowledge return path to clka.
- Unlike a plain toggle crossing, it tolerates back-to-back in_pulse: events queue in a clka-side pending counter and are delivered one by one over a 4-phase req/ack handshake.
- Exactly one single-cycle out_pulse is produced in clkb per accepted event.
- The sender gets busy and overflow status, so it can throttle or flag loss.

Parameters:
- SYNC_STAGES, 2, flops in each synchronizer chain (req into clkb, ack into clka); legal 2..4.
- CNT_W, 4, pending counter width; max queued events = 2**CNT_W-1.

Ports:
- clka  input  1  source clock.
- rst_n  input  1  reset, asynchronous, active-low; resets both domains.
- clkb  input  1  destination clock.
- in_pulse  input  1  event request (clka); each high cycle is one event.
- busy  output  1  (clka) high while state!=IDLE or pending!=0.
- pending  output  CNT_W  (clka) events queued, not yet launched.
- ovf_pulse  output  1  (clka) one-cycle pulse when an event is dropped at saturation.
- out_pulse  output  1  (clkb) one-cycle pulse per delivered event.

Behaviour:
- Reset: rst_n is asynchronous, active-low, clock clka. It clears all flops in both domains: req, sync chains, req_b_dly, FSM=IDLE, pending=0. Reset values of busy, pending, ovf_pulse and out_pulse are all 0.
- clka FSM states and transitions:
  - IDLE -> REQ on launch; req set 1.
  - REQ -> WAIT_LOW when ack_a==1; req set 0.
  - WAIT_LOW -> IDLE when ack_a==0.
- launch (combinational) = (state==IDLE) & (pending!=0 | in_pulse).
- Counter update: pending_next = pending + in_pulse - launch.
  - If pending==2**CNT_W-1, in_pulse=1 and launch=0: pending holds, ovf_pulse=1 next cycle, event dropped.
  - With launch=1, simultaneous in_pulse and launch cancel; no overflow is possible on that cycle.
- clkb side:
  - req passes through SYNC_STAGES flops to req_b.
  - req_b_dly registers req_b.
  - out_pulse = req_b & ~req_b_dly (rising edge only; the falling edge produces nothing).
  - ack_b = req_b, no extra flop.
- Return path: ack_b passes through SYNC_STAGES clka flops to ack_a.
- req must only change from a flop; no combinational logic is allowed in front of any sync chain.
- Latency with SYNC_STAGES=2 and clka==clkb in phase, in_pulse sampled at edge 0 from IDLE with pending=0:
  - Edge 0: req=1.
  - Edge 2: req_b=1; out_pulse high for the cycle edge2..edge3.
  - Edge 4: ack_a=1.
  - Edge 5: req=0.
  - Edge 9: ack_a=0.
  - Edge 10: FSM=IDLE.
  - Edge 11: next launch, if pending.
  - Event period is 11 clka cycles.
- Arbitrary clock ratio: correct for any clka:clkb ratio. No in_pulse spacing rule; rate is limited only by counter depth.
- busy falls the cycle after the last WAIT_LOW->IDLE transition with pending==0.
- Reset mid-handshake:
  - All queued and in-flight events are discarded.
  - No out_pulse during reset.
  - No spurious out_pulse after release, since req and req_b_dly both reset to 0.
  - Reset must be held for at least SYNC_STAGES+1 cycles of the slower clock.
- Assertions (sim only):
  - out_pulse never high on two consecutive clkb cycles.
  - req is stable while state==REQ until ack_a.
  - pending never wraps.

Test Plan:
1. Single event, clka==clkb, SYNC_STAGES=2: in_pulse at edge 0 -> out_pulse high only during edge2..edge3; busy 1 from edge 1, back to 0 after edge 10.
2. Three consecutive in_pulse cycles -> pending goes 0,1,2 after edges 0,1,2; exactly 3 out_pulses, 11 cycles apart; pending returns to 0, then busy=0.
3. Saturation, CNT_W=2, 6 back-to-back in_pulses -> pending saturates at 3; ovf_pulse fires twice; exactly 4 out_pulses total.
4. Slow clkb (clka 4x clkb), 5 pulses spaced 1 clka apart -> exactly 5 out_pulses, each 1 clkb cycle wide, none merged.
5. Fast clkb (clkb 3x clka), 10 randomly spaced pulses -> out_pulse count equals accepted in_pulse count; no back-to-back out_pulse.
6. Assert rst_n while state==REQ with pending=2 -> all outputs 0 within reset; after release, no out_pulse over 50 cycles and busy=0.

Source files
------------

// File: rtl/vi_sync_pulse_hs.sv
// Handshaked pulse crossing clka -> clkb: events queue in a clka-side counter and are delivered
// one at a time over a 4-phase req/ack handshake, one single-cycle out_pulse per event.
module vi_sync_pulse_hs #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             clkb,
  input  logic             in_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf_pulse,
  output logic             out_pulse
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (CNT_W < 1) begin : gen_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWaitLow} state_e;

  localparam logic [CNT_W-1:0] PendMax = '1;

  // clka domain
  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_a;
  logic                   launch;

  // clkb domain
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_b;
  logic                   req_b_dly_q;

  assign ack_a  = ack_sync_q[SYNC_STAGES-1];
  assign launch = (state_q == StIdle) && ((pending_q != '0) || in_pulse);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        if (ack_a) begin
          state_d = StWaitLow;
          req_d   = 1'b0;
        end
      end
      StWaitLow: begin
        if (!ack_a) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // A same-cycle in_pulse and launch cancel, so overflow is only possible when not launching.
  always_comb begin
    pending_d = pending_q;
    ovf_d     = 1'b0;
    if (in_pulse && !launch) begin
      if (pending_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!in_pulse && launch) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      pending_q  <= '0;
      ovf_q      <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      // ack_b is req_b itself; no flop between it and this chain.
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_b};
    end
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q  <= '0;
      req_b_dly_q <= 1'b0;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], req_q};
      req_b_dly_q <= req_b;
    end
  end

  assign req_b     = req_sync_q[SYNC_STAGES-1];
  assign out_pulse = req_b & ~req_b_dly_q;

  assign busy      = (state_q != StIdle) || (pending_q != '0);
  assign pending   = pending_q;
  assign ovf_pulse = ovf_q;

  out_pulse_single: assert property (@(posedge clkb) disable iff (!rst_n)
    out_pulse |=> !out_pulse);

  req_held_until_ack: assert property (@(posedge clka) disable iff (!rst_n)
    (state_q == StReq && !ack_a) |=> (state_q == StReq && req_q));

  pending_no_wrap_up: assert property (@(posedge clka) disable iff (!rst_n)
    (pending_q == PendMax) |=> (pending_q >= PendMax - 1'b1));

  pending_no_wrap_down: assert property (@(posedge clka) disable iff (!rst_n)
    (pending_q == '0) |=> (pending_q <= CNT_W'(1)));

endmodule

// File: tb/tb_vi_sync_pulse_hs.sv
// Directed bench for vi_sync_pulse_hs: in-phase latency, queueing, saturation, mid-handshake
// reset, and slow/fast destination clocks, with an expected-event queue as scoreboard.
module tb_vi_sync_pulse_hs;

  logic clka = 1'b0;
  logic clkb = 1'b0;
  logic rst_n = 1'b0;
  logic in_pulse = 1'b0;
  logic in_s = 1'b0;
  int   hb = 6;

  logic       busy, ovf_pulse, out_pulse;
  logic [3:0] pending;
  logic       busy_s, ovf_s, out_s;
  logic [1:0] pending_s;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int ovfs;
  logic prev;

  always #6 clka = ~clka;
  always #(hb) clkb = ~clkb;

  vi_sync_pulse_hs #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clka(clka), .rst_n(rst_n), .clkb(clkb), .in_pulse(in_pulse),
    .busy(busy), .pending(pending), .ovf_pulse(ovf_pulse), .out_pulse(out_pulse)
  );

  vi_sync_pulse_hs #(.SYNC_STAGES(2), .CNT_W(2)) dut_s (
    .clka(clka), .rst_n(rst_n), .clkb(clkb), .in_pulse(in_s),
    .busy(busy_s), .pending(pending_s), .ovf_pulse(ovf_s), .out_pulse(out_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pop one expected event; entries >= 0 also fix the clka edge index it must appear at.
  task automatic sb_pop(input string tag, input int k);
    logic had;
    int   e;
    had = (exp_q.size() != 0);
    e   = -1;
    if (had) e = exp_q.pop_front();
    chk({tag, "_expected"}, 32'(had), 32'd1);
    if (had && e >= 0) chk({tag, "_edge"}, k, e);
  endtask

  task automatic clka_step();
    @(posedge clka);
    #1;
  endtask

  task automatic watch_b(input string tag, input int ncyc);
    prev = 1'b0;
    repeat (ncyc) begin
      @(negedge clkb);
      if (out_pulse) begin
        sb_pop(tag, 0);
        chk({tag, "_b2b"}, 32'(prev), 32'd0);
      end
      prev = out_pulse;
    end
  endtask

  initial begin
    // Reset
    repeat (4) clka_step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ovf", 32'(ovf_pulse), 0);
    chk("rst_out", 32'(out_pulse), 0);
    chk("rst_busy_s", 32'(busy_s), 0);
    chk("rst_pending_s", 32'(pending_s), 0);
    chk("rst_ovf_s", 32'(ovf_s), 0);
    chk("rst_out_s", 32'(out_s), 0);
    rst_n = 1'b1;
    repeat (2) clka_step();

    // Test 1: single event, exact latency
    in_pulse = 1'b1;
    clka_step();
    in_pulse = 1'b0;
    chk("t1_busy_e0", 32'(busy), 1);
    chk("t1_pend_e0", 32'(pending), 0);
    chk("t1_out_e0", 32'(out_pulse), 0);
    for (int k = 1; k <= 12; k++) begin
      clka_step();
      chk($sformatf("t1_out_e%0d", k), 32'(out_pulse), 32'(k == 2));
      chk($sformatf("t1_busy_e%0d", k), 32'(busy), 32'(k < 10));
    end

    // Test 2: three back-to-back events, 11 cycles apart
    exp_q.push_back(2);
    exp_q.push_back(13);
    exp_q.push_back(24);
    for (int k = 0; k < 40; k++) begin
      in_pulse = (k < 3);
      clka_step();
      if (k < 3) chk($sformatf("t2_pend_e%0d", k), 32'(pending), k);
      if (out_pulse) sb_pop("t2_out", k);
    end
    in_pulse = 1'b0;
    chk("t2_sb_left", exp_q.size(), 0);
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_pend_end", 32'(pending), 0);
    chk("t2_ovf_end", 32'(ovf_pulse), 0);

    // Test 3: saturation with CNT_W=2
    ovfs = 0;
    exp_q.push_back(2);
    exp_q.push_back(13);
    exp_q.push_back(24);
    exp_q.push_back(35);
    for (int k = 0; k < 55; k++) begin
      in_s = (k < 6);
      clka_step();
      if (k < 6) chk($sformatf("t3_pend_e%0d", k), 32'(pending_s), (k < 3) ? k : 3);
      if (k < 8) chk($sformatf("t3_ovf_e%0d", k), 32'(ovf_s), 32'(k == 4 || k == 5));
      if (ovf_s) ovfs++;
      if (out_s) sb_pop("t3_out", k);
    end
    in_s = 1'b0;
    chk("t3_ovf_count", ovfs, 2);
    chk("t3_sb_left", exp_q.size(), 0);
    chk("t3_busy_end", 32'(busy_s), 0);

    // Test 6: reset while in REQ with two events queued
    for (int k = 0; k < 3; k++) begin
      in_pulse = 1'b1;
      clka_step();
    end
    in_pulse = 1'b0;
    chk("t6_pend_before", 32'(pending), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_pend_rst", 32'(pending), 0);
    chk("t6_ovf_rst", 32'(ovf_pulse), 0);
    chk("t6_out_rst", 32'(out_pulse), 0);
    for (int k = 0; k < 4; k++) begin
      clka_step();
      chk($sformatf("t6_out_in_rst%0d", k), 32'(out_pulse), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      clka_step();
      chk($sformatf("t6_out_post%0d", k), 32'(out_pulse), 0);
    end
    chk("t6_busy_post", 32'(busy), 0);
    chk("t6_pend_post", 32'(pending), 0);

    // Test 4: clkb four times slower than clka
    hb = 24;
    repeat (3) @(negedge clkb);
    clka_step();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          in_pulse = 1'b1;
          exp_q.push_back(-1);
          clka_step();
        end
        in_pulse = 1'b0;
      end
      watch_b("t4_out", 80);
    join
    chk("t4_sb_left", exp_q.size(), 0);
    chk("t4_busy_end", 32'(busy), 0);
    chk("t4_pend_end", 32'(pending), 0);

    // Test 5: clkb three times faster, random spacing
    hb = 2;
    repeat (6) @(negedge clkb);
    clka_step();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          in_pulse = 1'b1;
          exp_q.push_back(-1);
          clka_step();
          in_pulse = 1'b0;
          repeat ($urandom_range(0, 4)) clka_step();
        end
      end
      watch_b("t5_out", 1200);
    join
    chk("t5_sb_left", exp_q.size(), 0);
    chk("t5_busy_end", 32'(busy), 0);
    chk("t5_pend_end", 32'(pending), 0);
    chk("t5_ovf_end", 32'(ovf_pulse), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
